// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU sequencer: FSM states, instruction type codes,
// branch condition codes, special opcodes and instruction field positions.
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } state_t;

   localparam logic [1:0] TY_DATA   = 2'b00;
   localparam logic [1:0] TY_MEM    = 2'b01;
   localparam logic [1:0] TY_BRANCH = 2'b10;
   localparam logic [1:0] TY_SYS    = 2'b11;

   localparam logic [3:0] CC_AL = 4'b0000;
   localparam logic [3:0] CC_EQ = 4'b0001;
   localparam logic [3:0] CC_NE = 4'b0010;
   localparam logic [3:0] CC_MI = 4'b0011;
   localparam logic [3:0] CC_PL = 4'b0100;

   localparam logic [3:0] OP_CMP  = 4'b1010;
   localparam logic [3:0] OP_LOAD = 4'b0000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam int TYPE_HI = 31;
   localparam int TYPE_LO = 30;
   localparam int OP_HI   = 29;
   localparam int OP_LO   = 26;
   localparam int IMM_BIT = 25;

   // Only bits [31:25] steer control; the IR keeps just that slice.
   localparam int IR_W = TYPE_HI - IMM_BIT + 1;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of the latched instruction fields into control
// qualifiers, plus branch condition evaluation against the latched flags.
module instr_field_decode
   import alu_ctrl_pkg::*;
(
   input  logic [IR_W-1:0] ir,
   input  logic            flag_z,
   input  logic            flag_n,
   output logic [1:0]      itype,
   output logic [3:0]      opcode,
   output logic            imm,
   output logic            is_cmp,
   output logic            is_load,
   output logic            is_halt,
   output logic            cond_true
);

   assign itype   = ir[TYPE_HI-IMM_BIT : TYPE_LO-IMM_BIT];
   assign opcode  = ir[OP_HI-IMM_BIT : OP_LO-IMM_BIT];
   assign imm     = ir[0];
   assign is_cmp  = (itype == TY_DATA) && (opcode == OP_CMP);
   assign is_load = (itype == TY_MEM)  && (opcode == OP_LOAD);
   assign is_halt = (itype == TY_SYS)  && (opcode == OP_HALT);

   always_comb begin
      cond_true = 1'b0;
      case (opcode)
         CC_AL:   cond_true = 1'b1;
         CC_EQ:   cond_true = flag_z;
         CC_NE:   cond_true = ~flag_z;
         CC_MI:   cond_true = flag_n;
         CC_PL:   cond_true = ~flag_n;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM around the ALU: fetch, decode, execute, memory and
// write-back sequencing with latched Z/N flags for conditional branches.
module alu_sequencer
   import alu_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        alu_zero,
   input  logic        alu_negative,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        addr_sel,
   output logic        reg_write,
   output logic        wb_sel,
   output logic        pc_inc,
   output logic        pc_load,
   output logic [3:0]  alu_opcode,
   output logic [1:0]  alu_typecode,
   output logic        alu_is_immediate,
   output logic        flag_z,
   output logic        flag_n,
   output logic        halted,
   output logic [2:0]  state_dbg
);

   state_t          state;
   logic [IR_W-1:0] ir_q;
   logic [1:0]      itype;
   logic [3:0]      opcode;
   logic            imm;
   logic            is_cmp;
   logic            is_load;
   logic            is_halt;
   logic            cond_true;
   logic            unused_instr;

   assign unused_instr = ^instr[IMM_BIT-1:0];

   instr_field_decode u_decode (
      .ir        (ir_q),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .itype     (itype),
      .opcode    (opcode),
      .imm       (imm),
      .is_cmp    (is_cmp),
      .is_load   (is_load),
      .is_halt   (is_halt),
      .cond_true (cond_true)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_FETCH;
         ir_q   <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (mem_ready) begin
                  ir_q  <= instr[TYPE_HI:IMM_BIT];
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: state <= is_halt ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE: begin
               case (itype)
                  TY_DATA: begin
                     flag_z <= alu_zero;
                     flag_n <= alu_negative;
                     state  <= is_cmp ? ST_FETCH : ST_WRITEBACK;
                  end
                  TY_MEM:  state <= ST_MEMORY;
                  default: state <= ST_FETCH;
               endcase
            end
            ST_MEMORY: begin
               if (mem_ready) state <= is_load ? ST_WRITEBACK : ST_FETCH;
            end
            ST_WRITEBACK: state <= ST_FETCH;
            ST_HALT:      state <= ST_HALT;
            default:      state <= ST_FETCH;
         endcase
      end
   end

   // Strobes are decoded from state and gated by reset so a held request
   // drops in the very cycle reset is raised.
   always_comb begin
      ir_write         = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      addr_sel         = 1'b0;
      reg_write        = 1'b0;
      wb_sel           = 1'b0;
      pc_inc           = 1'b0;
      pc_load          = 1'b0;
      alu_opcode       = 4'd0;
      alu_typecode     = 2'd0;
      alu_is_immediate = 1'b0;
      halted           = 1'b0;
      state_dbg        = 3'd0;
      if (!reset) begin
         state_dbg = state;
         if (state inside {ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK}) begin
            alu_opcode       = opcode;
            alu_typecode     = itype;
            alu_is_immediate = imm;
         end
         case (state)
            ST_FETCH: begin
               mem_read = 1'b1;
               ir_write = mem_ready;
               pc_inc   = mem_ready;
            end
            ST_EXECUTE: pc_load = (itype == TY_BRANCH) && cond_true;
            ST_MEMORY: begin
               addr_sel  = 1'b1;
               mem_read  = is_load;
               mem_write = ~is_load;
            end
            ST_WRITEBACK: begin
               reg_write = 1'b1;
               wb_sel    = is_load;
            end
            ST_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle strobe pattern and flag values.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        mem_ready;
   logic        alu_zero;
   logic        alu_negative;
   logic        ir_write, mem_read, mem_write, addr_sel, reg_write, wb_sel;
   logic        pc_inc, pc_load, alu_is_immediate, flag_z, flag_n, halted;
   logic [3:0]  alu_opcode;
   logic [1:0]  alu_typecode;
   logic [2:0]  state_dbg;

   int vectors = 0;
   int errors  = 0;

   // Model state: flags as the ISA defines them, and the current instruction.
   logic       mz = 1'b0;
   logic       mn = 1'b0;
   logic [1:0] cur_ty;
   logic [3:0] cur_op;
   logic       cur_imm;

   logic [20:0] obs;

   alu_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .instr            (instr),
      .mem_ready        (mem_ready),
      .alu_zero         (alu_zero),
      .alu_negative     (alu_negative),
      .ir_write         (ir_write),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .addr_sel         (addr_sel),
      .reg_write        (reg_write),
      .wb_sel           (wb_sel),
      .pc_inc           (pc_inc),
      .pc_load          (pc_load),
      .alu_opcode       (alu_opcode),
      .alu_typecode     (alu_typecode),
      .alu_is_immediate (alu_is_immediate),
      .flag_z           (flag_z),
      .flag_n           (flag_n),
      .halted           (halted),
      .state_dbg        (state_dbg)
   );

   always #5 clk = ~clk;

   assign obs = {ir_write, mem_read, mem_write, addr_sel, reg_write, wb_sel,
                 pc_inc, pc_load, alu_opcode, alu_typecode, alu_is_immediate,
                 halted, state_dbg, flag_z, flag_n};

   function automatic logic [20:0] mk(input logic irw, input logic mr,
                                      input logic mw, input logic as,
                                      input logic rw, input logic wb,
                                      input logic pi, input logic pl,
                                      input logic ctl, input logic hlt,
                                      input logic [2:0] st);
      return {irw, mr, mw, as, rw, wb, pi, pl,
              ctl ? cur_op : 4'd0, ctl ? cur_ty : 2'd0, ctl ? cur_imm : 1'b0,
              hlt, st, mz, mn};
   endfunction

   task automatic check_vec(input string tag, input logic [20:0] got,
                            input logic [20:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic rs, input logic mr,
                      input logic [20:0] exp);
      reset     = rs;
      mem_ready = mr;
      @(negedge clk);
      check_vec(tag, obs, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         cyc("reset", 1'b1, 1'($urandom_range(0, 1)),
             mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
         mz = 1'b0;
         mn = 1'b0;
      end
      reset = 1'b0;
   endtask

   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic az, input logic an, input int abort_at);
      logic taken;
      logic load;
      instr        = ins;
      alu_zero     = az;
      alu_negative = an;
      cur_ty       = ins[31:30];
      cur_op       = ins[29:26];
      cur_imm      = ins[25];
      for (int i = 0; i < fw; i++)
         cyc("fetch_wait", 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
      cyc("fetch", 1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0));
      instr = $urandom;
      cyc("decode", 1'b0, 1'($urandom_range(0, 1)),
          mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd1));
      if (cur_ty == 2'b11 && cur_op == 4'hF) begin
         for (int i = 0; i < 10; i++)
            cyc("halt", 1'b0, 1'($urandom_range(0, 1)),
                mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd5));
         do_reset();
         return;
      end
      case (cur_op)
         4'd0:    taken = 1'b1;
         4'd1:    taken = mz;
         4'd2:    taken = !mz;
         4'd3:    taken = mn;
         4'd4:    taken = !mn;
         default: taken = 1'b0;
      endcase
      taken = taken && (cur_ty == 2'b10);
      cyc("execute", 1'b0, 1'($urandom_range(0, 1)),
          mk(0, 0, 0, 0, 0, 0, 0, taken, 1, 0, 3'd2));
      if (cur_ty == 2'b00) begin
         mz = az;
         mn = an;
         if (cur_op != 4'b1010)
            cyc("writeback", 1'b0, 1'($urandom_range(0, 1)),
                mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'd4));
      end else if (cur_ty == 2'b01) begin
         load = (cur_op == 4'b0000);
         for (int i = 0; i < mw; i++) begin
            if (i == abort_at) begin
               cyc("mem_reset", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
               mz    = 1'b0;
               mn    = 1'b0;
               reset = 1'b0;
               return;
            end
            cyc("mem_wait", 1'b0, 1'b0, mk(0, load, !load, 1, 0, 0, 0, 0, 1, 0, 3'd3));
         end
         cyc("mem_done", 1'b0, 1'b1, mk(0, load, !load, 1, 0, 0, 0, 0, 1, 0, 3'd3));
         if (load)
            cyc("writeback", 1'b0, 1'($urandom_range(0, 1)),
                mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 3'd4));
      end
   endtask

   initial begin
      logic [3:0]  picks [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10};
      logic [31:0] ins;
      int          fw, mw, ab;
      reset        = 1'b1;
      instr        = '0;
      mem_ready    = 1'b0;
      alu_zero     = 1'b0;
      alu_negative = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      run_instr(32'h04000000, 0, 0, 1'b1, 1'b0, -1);
      run_instr(32'h28000000, 0, 0, 1'b0, 1'b1, -1);
      run_instr(32'h8C000000, 0, 0, 1'b0, 1'b0, -1);
      run_instr(32'h28000000, 0, 0, 1'b0, 1'b1, -1);
      run_instr(32'h90000000, 0, 0, 1'b0, 1'b0, -1);
      run_instr(32'h40000000, 0, 3, 1'b0, 1'b0, -1);
      run_instr(32'h28000000, 1, 0, 1'b1, 1'b1, -1);
      run_instr(32'h44000000, 0, 3, 1'b0, 1'b0, 1);
      run_instr(32'hFC000000, 0, 0, 1'b0, 1'b0, -1);

      for (int n = 0; n < 250; n++) begin
         ins[31:30] = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) ins[29:26] = 4'($urandom_range(0, 15));
         else ins[29:26] = picks[$urandom_range(0, 5)];
         ins[25:0] = 26'($urandom);
         fw = $urandom_range(0, 2);
         mw = $urandom_range(0, 2);
         ab = -1;
         if ($urandom_range(0, 14) == 0) begin
            ab = $urandom_range(0, mw);
            mw = mw + 1;
         end
         run_instr(ins, fw, mw, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ab);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
